counter_display: RTL and testbench
==================================

COUNTER_DISPLAY -- requirements
Module: counter_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles each digit is lit (legal range 2..2^20).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port load, input, 1, when high, capture data_in into the shadow register at the next edge.
REQ-005 SHALL have port data_in, input, 32, value to display, typically the Counter data_out bus.
REQ-006 SHALL have port an, output, 8, digit anodes, active-low; an[i] selects hex digit i (nibble data[4i+3:4i]).
REQ-007 SHALL have port seg, output, 7, segments a..g on seg[0]..seg[6], active-low.
REQ-008 SHALL have port dp, output, 1, decimal point, active-low, constant 1 (off) outside reset.
REQ-009 SHALL have port scan_tick, output, 1, one-cycle pulse on each digit advance.

Function
REQ-010 SHALL hold a 32-bit shadow register; load=1 at edge t makes shadow=data_in sampled at t; load=0 holds it.
REQ-011 SHALL run a prescaler counting 0..SCAN_DIV-1, wrapping to 0; terminal count sets scan_tick=1 for that cycle only.
REQ-012 SHALL advance a 3-bit digit index on the edge ending a terminal-count cycle; 7 wraps to 0.
REQ-013 SHALL register an, seg: values after edge t+1 reflect index and shadow after edge t (one-cycle latency).
REQ-014 SHALL drive exactly one an bit low (bit = index) except when blanked (REQ-022) or in reset.
REQ-015 SHALL decode nibbles 0..F to standard hex glyphs; active-low patterns seg[6:0]: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-016 SHALL let load be continuously high; the display then tracks data_in with two cycles of latency to seg.
REQ-017 SHALL not restart the prescaler or index on load; a load mid-digit changes seg of the lit digit one edge after the shadow update.
REQ-018 SHALL keep scan period 8*SCAN_DIV cycles exactly, independent of load activity.

Reset
REQ-019 SHALL, while rst=0, force shadow=0, prescaler=0, index=0, scan_tick=0, an=11111111, seg=1111111, dp=1, asynchronously.
REQ-020 SHALL, at the first edge after rst deasserts, present an=11111110, seg=1000000 (digit 0 showing 0).
REQ-021 SHALL abandon any scan in progress on reset mid-operation; no partial-digit state survives.

Configuration
REQ-022 SHALL, with LEADING_ZERO_BLANK_EN defined, blank digit i (an all ones for its slot, index still advances) when i>0 and nibbles i..7 of shadow are all zero; digit 0 is never blanked.
REQ-023 SHALL, without LEADING_ZERO_BLANK_EN, light every digit in turn including leading zeros.

Verification (SCAN_DIV=4)
REQ-024 SHALL verify: rst=0 for 3 cycles then release -> an=FF, seg=7F during reset; next edge an=FE, seg=40; scan_tick first high in cycle 4 after release.
REQ-025 SHALL verify: load 0x89ABCDEF one cycle -> over 32 cycles an walks FE,FD,...,7F each for 4 cycles, seg shows F,E,D,C,B,A,9,8.
REQ-026 SHALL verify: index 7 terminal count -> an returns FE; scan period measured 32 cycles between digit-0 starts with load toggling randomly.
REQ-027 SHALL verify: load 0x00000012 while digit 0 lit -> seg changes to glyph 2 one edge after shadow update, prescaler unaffected.
REQ-028 SHALL verify: rst asserted mid-digit 5 -> outputs reset immediately without clock; after release scan restarts at digit 0.
REQ-029 SHALL verify: LEADING_ZERO_BLANK_EN defined, shadow 0x00000012 -> an low only for digits 0,1; shadow 0 -> only digit 0 lit showing 0.

Source files
------------

// File: rtl/counter_display.sv
// Eight-digit multiplexed hex display driver: shadows a 32-bit value and scans it onto active-low anodes/segments.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always lit).
module counter_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        scan_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(SCAN_DIV - 1);

  logic [31:0]      shadow_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [2:0]       idx_p0;
  logic [7:0]       an_p1;
  logic [6:0]       seg_p1;
  logic [3:0]       nib_p0;
  logic             blank_p0;

  // Active-low glyphs, bit order g f e d c b a.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign scan_tick = (cnt_p0 == TERM);
  assign nib_p0    = shadow_p0[{idx_p0, 2'b00} +: 4];
  assign dp        = 1'b1;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more-significant nibble are zero.
  assign blank_p0 = (idx_p0 != 3'd0) &&
                    ((shadow_p0 & (32'hFFFF_FFFF << {idx_p0, 2'b00})) == 32'd0);
`else
  assign blank_p0 = 1'b0;
`endif

  // Stage p0: shadow register, prescaler and digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_p0 <= '0;
      cnt_p0    <= '0;
      idx_p0    <= '0;
    end else begin
      if (load)
        shadow_p0 <= data_in;
      if (scan_tick) begin
        cnt_p0 <= '0;
        idx_p0 <= idx_p0 + 3'd1;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

  // Stage p1: registered anode/segment drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_p1  <= 8'hFF;
      seg_p1 <= 7'h7F;
    end else if (blank_p0) begin
      an_p1  <= 8'hFF;
      seg_p1 <= 7'h7F;
    end else begin
      an_p1  <= ~(8'd1 << idx_p0);
      seg_p1 <= hex_glyph(nib_p0);
    end
  end

  assign an  = an_p1;
  assign seg = seg_p1;

endmodule

// File: tb/tb_counter_display.sv
// Directed bench for counter_display with SCAN_DIV=4: vector table for the full scan, hand sequences for reset/load corners.
module tb_counter_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        scan_tick;

  int n_cmp = 0;
  int n_bad = 0;

  counter_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in),
    .an(an), .seg(seg), .dp(dp), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [31:0] din;
    int          reps;
    logic [7:0]  an;
    logic [6:0]  seg;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int nstart;
    int starts[3];
    logic [7:0] prev;
    bit found;
    int fe_cnt, other_cnt;

    // {load, data_in, edges, an, seg} after each edge following reset release
    tbl[0] = '{1'b1, 32'h89AB_CDEF, 1, 8'hFE, 7'h40};
    tbl[1] = '{1'b0, 32'h0,         3, 8'hFE, 7'h0E};
    tbl[2] = '{1'b0, 32'h0,         4, 8'hFD, 7'h06};
    tbl[3] = '{1'b0, 32'h0,         4, 8'hFB, 7'h21};
    tbl[4] = '{1'b0, 32'h0,         4, 8'hF7, 7'h46};
    tbl[5] = '{1'b0, 32'h0,         4, 8'hEF, 7'h03};
    tbl[6] = '{1'b0, 32'h0,         4, 8'hDF, 7'h08};
    tbl[7] = '{1'b0, 32'h0,         4, 8'hBF, 7'h10};
    tbl[8] = '{1'b0, 32'h0,         4, 8'h7F, 7'h00};
    tbl[9] = '{1'b0, 32'h0,         4, 8'hFE, 7'h0E};

    rst = 1'b0; load = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an",   an,        8'hFF);
    chk("rst_seg",  seg,       7'h7F);
    chk("rst_dp",   dp,        1'b1);
    chk("rst_tick", scan_tick, 1'b0);

    rst = 1'b1;
    chk("tick_cycle1", scan_tick, 1'b0);

    e = 0;
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        load = tbl[r].ld;
        data_in = tbl[r].din;
        step();
        e++;
        chk($sformatf("walk_an_e%0d", e),   an,        tbl[r].an);
        chk($sformatf("walk_seg_e%0d", e),  seg,       tbl[r].seg);
        chk($sformatf("walk_tick_e%0d", e), scan_tick, (e % 4) == 3);
      end
    end

    // Scan period with load toggling
    nstart = 0;
    e = 0;
    for (int i = 0; i < 200 && nstart < 3; i++) begin
      prev = an;
      load = 1'($urandom_range(0, 1));
      data_in = $urandom;
      step();
      e++;
      if (an == 8'hFE && prev != 8'hFE) begin
        starts[nstart] = e;
        nstart++;
      end
    end
    if (nstart < 3) begin
      n_cmp++; n_bad++;
      $display("FAIL period_timeout: got %0d starts want 3", nstart);
    end else begin
      chk("period_1", starts[1] - starts[0], 32);
      chk("period_2", starts[2] - starts[1], 32);
    end

    // Reset in the middle of digit 5
    load = 1'b1; data_in = 32'h89AB_CDEF;
    step();
    load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      prev = an;
      step();
      if (an == 8'hDF && prev != 8'hDF) found = 1'b1;
    end
    chk("found_digit5", found, 1'b1);
    step();
    #2 rst = 1'b0;
    #1;
    chk("async_an",   an,        8'hFF);
    chk("async_seg",  seg,       7'h7F);
    chk("async_tick", scan_tick, 1'b0);
    chk("async_dp",   dp,        1'b1);
    repeat (2) step();
    chk("hold_an", an, 8'hFF);

    rst = 1'b1;
    step();
    chk("restart_an",   an,        8'hFE);
    chk("restart_seg",  seg,       7'h40);
    chk("restart_tick", scan_tick, 1'b0);
    load = 1'b1; data_in = 32'h0000_0012;
    step();
    chk("ld_e2_an",   an,        8'hFE);
    chk("ld_e2_seg",  seg,       7'h40);
    chk("ld_e2_tick", scan_tick, 1'b0);
    load = 1'b0;
    step();
    chk("ld_e3_an",   an,        8'hFE);
    chk("ld_e3_seg",  seg,       7'h24);
    chk("ld_e3_tick", scan_tick, 1'b1);
    step();
    chk("ld_e4_seg",  seg,       7'h24);
    chk("ld_e4_tick", scan_tick, 1'b0);
    step();
    chk("ld_e5_an",   an,        8'hFD);
    chk("ld_e5_seg",  seg,       7'h79);

`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 6; k <= 32; k++) begin
      step();
      chk($sformatf("blank12_an_e%0d", k), an, (k <= 8) ? 8'hFD : 8'hFF);
    end
    step();
    chk("blank12_wrap_an",  an,  8'hFE);
    chk("blank12_wrap_seg", seg, 7'h24);
    load = 1'b1; data_in = 32'h0;
    step();
    load = 1'b0;
    step();
    fe_cnt = 0; other_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (an == 8'hFE) begin
        fe_cnt++;
        chk("blank0_seg", seg, 7'h40);
      end else if (an != 8'hFF) begin
        other_cnt++;
      end
    end
    chk("blank0_fe_cnt", fe_cnt, 4);
    chk("blank0_other",  other_cnt, 0);
`else
    for (int k = 6; k <= 12; k++) begin
      step();
      chk($sformatf("lead0_an_e%0d", k),  an,  (k <= 8) ? 8'hFD : 8'hFB);
      chk($sformatf("lead0_seg_e%0d", k), seg, (k <= 8) ? 7'h79 : 7'h40);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
